// File: rtl/io_crc_frame_ctrl.sv
// Frame controller that shares one CRC16 engine between two receive channels,
// checks each frame's trailing CRC word and keeps saturating frame statistics.
module io_crc_frame_ctrl #(
   parameter int unsigned MAX_WORDS = 128,
   parameter int unsigned TMO_CYC   = 1023
) (
   input  logic        clk_sys,
   input  logic        rst_sys_n,
   input  logic [15:0] ch0_din,
   input  logic        ch0_vld,
   input  logic        ch0_eof,
   output logic        ch0_rdy,
   input  logic [15:0] ch1_din,
   input  logic        ch1_vld,
   input  logic        ch1_eof,
   output logic        ch1_rdy,
   output logic        eng_sop,
   output logic [15:0] eng_din,
   output logic        eng_din_vld,
   output logic        eng_cap,
   input  logic [15:0] eng_dout,
   output logic        res_vld,
   output logic        res_ch,
   output logic        res_ok,
   output logic        res_len_err,
   output logic        res_tmo,
   output logic [7:0]  res_words,
   output logic [15:0] frm_ok_cnt,
   output logic [15:0] frm_err_cnt
);

   localparam logic [7:0]  MAX_W    = 8'(MAX_WORDS);
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

   typedef enum logic [1:0] {IDLE, SOP, DATA, DRAIN} state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t      state, state_nxt;
   logic        grant, grant_nxt;
   logic        last_grant, last_grant_nxt;
   logic [7:0]  word_cnt, word_cnt_nxt;
   logic        len_err, len_err_nxt;
   logic [15:0] tmo_cnt, tmo_cnt_nxt;

   logic        busy;
   logic        acc;
   logic [15:0] sel_din;
   logic        sel_vld;
   logic        sel_eof;

   logic        res_fire;
   logic        res_ok_nxt;
   logic        res_len_err_nxt;
   logic        res_tmo_nxt;
   logic [7:0]  res_words_nxt;

   // rdy is a function of state and grant only, so the sender never sees a combinational loop
   assign busy    = (state == DATA) || (state == DRAIN);
   assign ch0_rdy = busy & ~grant;
   assign ch1_rdy = busy & grant;
   assign sel_din = grant ? ch1_din : ch0_din;
   assign sel_vld = grant ? ch1_vld : ch0_vld;
   assign sel_eof = grant ? ch1_eof : ch0_eof;
   assign acc     = busy & sel_vld;

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      last_grant_nxt  = last_grant;
      word_cnt_nxt    = word_cnt;
      len_err_nxt     = len_err;
      tmo_cnt_nxt     = tmo_cnt;
      res_fire        = 1'b0;
      res_ok_nxt      = 1'b0;
      res_len_err_nxt = len_err;
      res_tmo_nxt     = 1'b0;
      res_words_nxt   = word_cnt;
      eng_sop         = 1'b0;
      eng_din         = 16'h0000;
      eng_din_vld     = 1'b0;
      eng_cap         = 1'b0;
      case (state)
         IDLE: begin
            if (ch0_vld || ch1_vld) begin
               grant_nxt      = (ch0_vld && ch1_vld) ? ~last_grant : ch1_vld;
               last_grant_nxt = grant_nxt;
               state_nxt      = SOP;
            end
         end
         SOP: begin
            eng_sop      = 1'b1;
            word_cnt_nxt = 8'd0;
            len_err_nxt  = 1'b0;
            tmo_cnt_nxt  = 16'd0;
            state_nxt    = DATA;
         end
         DATA, DRAIN: begin
            if (acc) begin
               tmo_cnt_nxt = 16'd0;
               if (sel_eof) begin
                  // eng_dout already holds the capture of the last payload word here
                  res_fire        = 1'b1;
                  res_ok_nxt      = (sel_din == eng_dout) && (word_cnt != 8'd0) && !len_err;
                  res_len_err_nxt = len_err || (word_cnt == 8'd0);
                  state_nxt       = IDLE;
               end else if (state == DATA) begin
                  if (word_cnt < MAX_W) begin
                     eng_din      = sel_din;
                     eng_din_vld  = 1'b1;
                     eng_cap      = 1'b1;
                     word_cnt_nxt = word_cnt + 8'd1;
                  end else begin
                     len_err_nxt = 1'b1;
                     state_nxt   = DRAIN;
                  end
               end
            end else if (tmo_cnt == TMO_LAST) begin
               res_fire    = 1'b1;
               res_tmo_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         word_cnt    <= 8'd0;
         len_err     <= 1'b0;
         tmo_cnt     <= 16'd0;
         res_vld     <= 1'b0;
         res_ch      <= 1'b0;
         res_ok      <= 1'b0;
         res_len_err <= 1'b0;
         res_tmo     <= 1'b0;
         res_words   <= 8'd0;
         frm_ok_cnt  <= 16'd0;
         frm_err_cnt <= 16'd0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         word_cnt   <= word_cnt_nxt;
         len_err    <= len_err_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         res_vld    <= res_fire;
         // result stage: fields hold until the next frame reports
         if (res_fire) begin
            res_ch      <= grant;
            res_ok      <= res_ok_nxt;
            res_len_err <= res_len_err_nxt;
            res_tmo     <= res_tmo_nxt;
            res_words   <= res_words_nxt;
            if (res_ok_nxt) frm_ok_cnt  <= sat_inc16(frm_ok_cnt);
            else            frm_err_cnt <= sat_inc16(frm_err_cnt);
         end
      end
   end

endmodule

// File: doc/io_crc_frame_ctrl.md
# io_crc_frame_ctrl

Frame-level controller that shares one 16-bit-wide CRC16 engine (x^16 + x^12 + x^5 + 1, init 0xFFFF) between two receive channels. It grants one channel per frame with round-robin arbitration and drives the engine's start, data-valid and capture strobes. It then compares the engine result against the trailing CRC word of each frame and reports per-frame status and saturating statistics. It sits between the IO link receivers and the frame buffer, clocked on clk_sys (125 MHz).

## Interface
- MAX_WORDS, 128: maximum payload words per frame, CRC word excluded; range 1..255.
- TMO_CYC, 1023: idle cycles allowed mid-frame before abort; range 1..65535.
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset; asynchronous, active-low. Clock is clk_sys.
- ch0_din / ch1_din  in  16  channel word.
- ch0_vld / ch1_vld  in  1  word valid.
- ch0_eof / ch1_eof  in  1  the current word is the frame's CRC word (last word).
- ch0_rdy / ch1_rdy  out  1  word accepted when vld & rdy.
- eng_sop  out  1  engine restart to 0xFFFF.
- eng_din  out  16  engine data.
- eng_din_vld  out  1  engine update.
- eng_cap  out  1  engine capture.
- eng_dout  in  16  engine captured CRC; valid 1 cycle after eng_cap.
- res_vld  out  1  one-cycle result strobe.
- res_ch  out  1  channel of the result.
- res_ok  out  1  CRC matched, no error.
- res_len_err  out  1  zero or over-length payload.
- res_tmo  out  1  frame aborted on timeout.
- res_words  out  8  payload words counted, saturating at MAX_WORDS.
- frm_ok_cnt / frm_err_cnt  out  16  saturating frame counters.

## Operation
- States: IDLE, SOP, DATA, DRAIN.
- **IDLE**
  - If any chN_vld is high, grant one channel. When both are valid, grant the channel not granted last.
  - last_grant resets to 1, so ch0 wins the first tie.
  - Go to SOP.
- **SOP**
  - Drive eng_sop=1 for exactly 1 cycle with both rdy low.
  - Clear word_cnt, len_err and tmo_cnt.
  - Go to DATA.
- **DATA**
  - rdy is high for the granted channel only. rdy depends on state and grant only, never on vld.
  - Accepted non-eof word, word_cnt < MAX_WORDS:
    - eng_din = word; eng_din_vld = 1; eng_cap = 1, all combinational in the same cycle.
    - word_cnt increments.
  - Accepted non-eof word, word_cnt == MAX_WORDS:
    - Word is consumed but not fed to the engine; set len_err.
    - Go to DRAIN.
  - Accepted eof word:
    - ok = (word == eng_dout) & (word_cnt != 0) & ~len_err.
    - word_cnt == 0 sets len_err.
    - Register the result and go to IDLE.
- **DRAIN**
  - Granted rdy stays high and words are discarded with no engine strobes.
  - On the eof word, report ok=0, len_err=1, then go to IDLE.
- **Timeout**
  - In DATA or DRAIN, tmo_cnt increments on every cycle without an accepted word and clears on acceptance.
  - When tmo_cnt reaches TMO_CYC, report ok=0, tmo=1 and go to IDLE. Later words of that frame are treated as a new frame.
- **Results and counters**
  - Every result pulses res_vld once.
  - res_ok=1 increments frm_ok_cnt; otherwise frm_err_cnt increments.
  - Both counters saturate at 0xFFFF.
- eng_din is 0 whenever eng_din_vld=0. eng_sop, eng_din_vld and eng_cap are never high together with eng_sop.
- The ungranted channel's vld is ignored; its rdy stays 0.

## Timing
- Reset values:
  - All outputs 0, counters 0, state IDLE, last_grant 1.
  - Reset mid-frame abandons the frame with no res_vld.
- Frame latency:
  - vld in IDLE at cycle t, SOP at t+1, first word accepted at t+2 at the earliest.
  - Result registered on the edge after eof acceptance: res_vld high for the following cycle, while the FSM is already in IDLE.
- Throughput: one word per cycle in DATA. Back-to-back frames cost 2 idle cycles (IDLE, SOP) per frame.
- eng_dout comparison: the eof word can arrive at the earliest the cycle after the last payload word. eng_dout has been updated by then (cap to dout takes 1 cycle).
- res_ch, res_ok, res_len_err, res_tmo and res_words hold their value until the next result.

## Test plan
- **Single word, good CRC:** ch0 sends payload 0x0000 then eof 0x1D0F -> res_vld=1, res_ch=0, res_ok=1, res_words=1, frm_ok_cnt=1, 1 eng_sop and 1 eng_din_vld pulse.
- **Bad CRC:** ch1 sends 0x0000 then eof 0x1D0E -> res_ok=0, res_len_err=0, frm_err_cnt=1.
- **Tie arbitration:** ch0 and ch1 both valid from reset, each sending 3-word frames -> grant order ch0, ch1, ch0. No rdy overlap. Each frame's CRC matches the engine reference model.
- **Length limits:**
  - eof as the first word -> res_len_err=1, res_words=0.
  - MAX_WORDS+5 payload words -> engine fed exactly MAX_WORDS words, res_len_err=1, res_words=MAX_WORDS.
- **Timeout:** TMO_CYC=8, vld dropped for 8 cycles mid-frame -> res_tmo=1, res_ok=0, FSM in IDLE. Next vld starts a new SOP.
- **Reset mid-frame:** rst_sys_n low during DATA -> all outputs 0 and no res_vld. A following good frame reports res_ok=1.
